// File: rtl/kbd_char_fifo_pkg.sv
// ============================================================================
//  Module   : kbd_char_fifo_pkg
//  Purpose  : Shared sizes and operation decode for the keyboard character FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package kbd_char_fifo_pkg;

   localparam int KBD_FIFO_DEPTH = 16;
   localparam int KBD_FIFO_AW    = 4;
   localparam int KBD_ASCII_W    = 8;

   typedef enum logic [1:0] {
      OP_IDLE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_BOTH = 2'd3
   } fifo_op_e;

   // Collapses the accepted push/pop pair into one pointer/count update kind.
   function automatic fifo_op_e fifo_op(input logic push, input logic pop);
      fifo_op_e op;
      op = OP_IDLE;
      if (push && pop) begin
         op = OP_BOTH;
      end else if (push) begin
         op = OP_PUSH;
      end else if (pop) begin
         op = OP_POP;
      end
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_fifo_mem.sv
// ============================================================================
//  Module   : kbd_fifo_mem
//  Purpose  : DEPTH x DATA_W storage, one synchronous write and one synchronous read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_fifo_mem
   import kbd_char_fifo_pkg::*;
#(
   parameter int DEPTH  = KBD_FIFO_DEPTH,
   parameter int ADDR_W = KBD_FIFO_AW,
   parameter int DATA_W = KBD_ASCII_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Array is left without reset so it can map onto RAM primitives.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register holds its value between pops; a same-address write
   // returns the old contents (read-before-write).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/kbd_char_fifo.sv
// ============================================================================
//  Module   : kbd_char_fifo
//  Purpose  : Keyboard character buffer with status, sticky overflow and level IRQ.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_char_fifo
   import kbd_char_fifo_pkg::*;
#(
   parameter int DEPTH  = KBD_FIFO_DEPTH,
   parameter int ADDR_W = KBD_FIFO_AW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   char_rda,
   input  logic [KBD_ASCII_W-1:0] char_in,
   input  logic                   rd_en,
   input  logic                   flush,
   input  logic                   clr_ovf,
   output logic [KBD_ASCII_W-1:0] rd_data,
   output logic                   rd_valid,
   output logic                   empty,
   output logic                   full,
   output logic [ADDR_W:0]        count,
   output logic                   overflow,
   output logic                   irq
);

   localparam logic [ADDR_W:0] c_full_count = (ADDR_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] wp_q, wp_d;
   logic [ADDR_W-1:0] rp_q, rp_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              rd_valid_q, rd_valid_d;

   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   fifo_op_e          w_op;

   assign w_empty = (count_q == '0);
   assign w_full  = (count_q == c_full_count);

   // A read on a full buffer frees the slot, so the write is accepted too.
   assign w_pop  = rd_en && !flush && !w_empty;
   assign w_push = char_rda && !flush && (!w_full || w_pop);
   assign w_drop = char_rda && !flush && w_full && !w_pop;
   assign w_op   = fifo_op(w_push, w_pop);

   always_comb begin
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q;
      rd_valid_d = w_pop;
      ovf_d      = ovf_q;

      unique case (w_op)
         OP_PUSH: begin
            wp_d    = wp_q + 1'b1;
            count_d = count_q + 1'b1;
         end
         OP_POP: begin
            rp_d    = rp_q + 1'b1;
            count_d = count_q - 1'b1;
         end
         OP_BOTH: begin
            wp_d = wp_q + 1'b1;
            rp_d = rp_q + 1'b1;
         end
         default: begin
         end
      endcase

      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   kbd_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (KBD_ASCII_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (w_push),
      .waddr_i (wp_q),
      .wdata_i (char_in),
      .re_i    (w_pop),
      .raddr_i (rp_q),
      .rdata_o (rd_data)
   );

   assign rd_valid = rd_valid_q;
   assign empty    = w_empty;
   assign full     = w_full;
   assign count    = count_q;
   assign overflow = ovf_q;
   assign irq      = !w_empty;

endmodule

`default_nettype wire
